// File: rtl/dbus_uart_if.sv
// rtl/dbus_uart_if.sv - data bus between the CPU execute stage and dbus_uart
//
// Purpose: groups the per-cycle memory access signals of the data bus.
// Ports:
//   mem_addr   byte address, valid every cycle (master -> slave)
//   mem_wdata  lane-replicated store data (master -> slave)
//   mem_write  per-byte write enables, 0 = read only (master -> slave)
//   mem_rdata  registered read data for the previous cycle's address (slave -> master)
interface dbus_uart_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_write;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_write, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_write, output mem_rdata);
endinterface

// File: rtl/dbus_uart.sv
// rtl/dbus_uart.sv - data RAM plus memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose: decodes the CPU data bus into a read-first byte-writable RAM at
// 0x0000_0000, a UART data register at 0x1000_0000 (write pushes a byte into
// the TX FIFO) and a UART status register at 0x1000_0004.
// Ports:
//   clk      single clock, all state updates on the rising edge
//   reset    synchronous, active-high reset
//   bus      dbus_uart_if slave: mem_addr/mem_wdata/mem_write in, mem_rdata out
//   uart_tx  serial transmit line, idle high, driven from a flop
module dbus_uart #(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  dbus_uart_if.slave bus,
  output logic       uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_STAT} rd_sel_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  // Address decode; the two low address bits never select anything.
  logic sel_ram, sel_data, sel_stat;
  assign sel_ram  = (bus.mem_addr[31:AW+2] == '0);
  assign sel_data = (bus.mem_addr[31:2] == 30'h0400_0000);
  assign sel_stat = (bus.mem_addr[31:2] == 30'h0400_0001);

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, bus.mem_addr[1:0]};

  // Data RAM: no reset, read-first so a same-cycle store returns old data.
  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_q;
  logic [AW-1:0] ram_idx;
  assign ram_idx = bus.mem_addr[AW+1:2];

  always_ff @(posedge clk) begin
    ram_q <= ram[ram_idx];
    if (sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_write[i]) ram[ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // TX FIFO
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          full, empty, push, pop, accept, overflow;
  tx_state_t     state;

  assign full   = (count == 5'(FIFO_DEPTH));
  assign empty  = (count == 5'd0);
  assign push   = sel_data && bus.mem_write[0];
  assign pop    = (state == S_IDLE) && !empty;
  // A full FIFO still takes a byte when the transmitter frees a slot this cycle.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)    rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (push && !accept)
        overflow <= 1'b1;
      else if (sel_stat && bus.mem_write[0] && bus.mem_wdata[3])
        overflow <= 1'b0;
    end
  end

  // Transmitter FSM; uart_tx is registered and changes together with the state.
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty) begin
            shift   <= fifo[rd_ptr];
            baud    <= CW'(CLK_DIV - 1);
            state   <= S_START;
            uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (baud == '0) begin
            baud    <= CW'(CLK_DIV - 1);
            bit_idx <= '0;
            state   <= S_DATA;
            uart_tx <= shift[0];
          end else begin
            baud <= baud - CW'(1);
          end
        end
        S_DATA: begin
          if (baud == '0) begin
            baud <= CW'(CLK_DIV - 1);
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud <= baud - CW'(1);
          end
        end
        S_STOP: begin
          if (baud == '0) state <= S_IDLE;
          else            baud  <= baud - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read path: status is captured with the address, RAM data comes from ram_q.
  logic [7:0] stat, stat_q;
  rd_sel_t    rd_sel;
  assign stat = {count[3:0], overflow, empty, full, state != S_IDLE};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel <= RD_NONE;
      stat_q <= '0;
    end else begin
      rd_sel <= sel_ram ? RD_RAM : (sel_stat ? RD_STAT : RD_NONE);
      stat_q <= stat;
    end
  end

  assign bus.mem_rdata = (rd_sel == RD_RAM)  ? ram_q :
                         (rd_sel == RD_STAT) ? {24'b0, stat_q} : 32'h0;

endmodule

// File: doc/dbus_uart.md
DBUS_UART -- requirements
Module: dbus_uart

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, <=16).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_addr  input  32  byte address from execute stage, valid every cycle.
REQ-007 mem_wdata  input  32  store data, already lane-replicated by the CPU.
REQ-008 mem_write  input  4  per-byte write enables; 0 means no write.
REQ-009 mem_rdata  output  32  registered read data for the address of the previous cycle.
REQ-010 uart_tx  output  1  serial 8N1 transmit line, idle high.

Function
REQ-011 Address map SHALL be: RAM 0x0000_0000..RAM_WORDS*4-1; UART_DATA 0x1000_0000; UART_STAT 0x1000_0004; everything else unmapped.
REQ-012 Reads SHALL be side-effect free; mem_rdata at cycle N+1 SHALL reflect mem_addr at cycle N (one-cycle latency, full word, mem_addr[1:0] ignored).
REQ-013 RAM word index SHALL be mem_addr[log2(RAM_WORDS)+1:2]; each byte lane i SHALL be written with mem_wdata[8i+7:8i] when mem_write[i]=1.
REQ-014 RAM read-during-write to the same word SHALL return the old contents (read-first).
REQ-015 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-016 Write to UART_DATA with mem_write[0]=1 SHALL push mem_wdata[7:0] into the TX FIFO.
REQ-017 Push SHALL be accepted if FIFO not full, or if full and a pop occurs in the same cycle; otherwise the byte is dropped and sticky overflow is set.
REQ-018 UART_DATA read SHALL return 0.
REQ-019 UART_STAT read SHALL return {24'b0, count[3:0], overflow, empty, full, busy} (busy = FSM not IDLE).
REQ-020 Write to UART_STAT with mem_write[0]=1 and mem_wdata[3]=1 SHALL clear overflow; set-by-drop in the same cycle SHALL win.
REQ-021 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 IDLE: uart_tx=1; if FIFO non-empty, pop head into shift register, load baud counter CLK_DIV-1, go START.
REQ-023 START: uart_tx=0 for CLK_DIV cycles, then DATA with bit index 0.
REQ-024 DATA: uart_tx=shift[0], LSB first, each bit CLK_DIV cycles; after bit 7 go STOP.
REQ-025 STOP: uart_tx=1 for CLK_DIV cycles, then IDLE; next byte may start the following cycle (back-to-back frames of 10*CLK_DIV+1 cycles).
REQ-026 uart_tx SHALL be driven from a flop (glitch-free).
REQ-027 FIFO count SHALL never exceed FIFO_DEPTH; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On reset: mem_rdata=0, uart_tx=1, FSM=IDLE, FIFO empty (count=0), overflow=0, baud counter=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; uart_tx=1 after the reset edge; queued bytes discarded.
REQ-030 RAM contents SHALL NOT be reset.

Verification
REQ-031 sw 0xDEADBEEF to 0x10, then sb 0x55 mem_write=4'b0100 to 0x12, read 0x10 -> mem_rdata=0xDE55BEEF one cycle after address.
REQ-032 Read 0x2000_0000 -> 0; write there then read RAM word 0 -> unchanged.
REQ-033 CLK_DIV=4, push 0xA5 -> uart_tx low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; busy=1 throughout, STAT then reads 0x4 (empty).
REQ-034 FIFO_DEPTH=8, push 10 bytes while FSM busy -> count reaches 8 after first pop accounted, overflow=1, full=1; write STAT 0x8 -> overflow=0.
REQ-035 Push 2 bytes with CLK_DIV=4 -> second start bit begins 1 cycle after first stop bit ends; total 81 cycles from first pop.
REQ-036 Assert reset during DATA bit 3 -> uart_tx=1 next cycle, STAT reads 0x4, no further frame.
